// File: rtl/boundary_collision.sv
`default_nettype none
// ============================================================================
// Module   : boundary_collision
// Brief    : Wall/brick contact detector that owns the ball direction bits,
//            with per-axis rebound lockout, wall-bounce sound timer and an
//            optional sticky top-wall flag (build macro TOP_HIT_FLAG_EN).
// Revision : 1.0 - initial release
// ============================================================================
module boundary_collision #(
    parameter int SND_FRAMES = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic PIX_CE,
    input  logic VSYNC_N,
    input  logic BALL,
    input  logic TOP_BOUND,
    input  logic LH_SIDE,
    input  logic RH_SIDE,
    input  logic BRICK_HIT,
    input  logic SERVE,
    input  logic SERVE_HDIR,
    output logic HDIR,
    output logic VDIR,
    output logic WALL_SND,
    output logic TOP_HIT
);

    localparam logic [0:0] c_ARMED    = 1'b0;
    localparam logic [0:0] c_LOCKED   = 1'b1;
    localparam logic [3:0] c_SND_LOAD = 4'(SND_FRAMES);

    logic       r_vs_q;
    logic       r_frame_q;
    logic [0:0] r_h_state_q, w_h_state_d;
    logic [0:0] r_v_state_q, w_v_state_d;
    logic       r_h_seen_q,  w_h_seen_d;
    logic       r_v_seen_q,  w_v_seen_d;
    logic       r_hdir_q,    w_hdir_d;
    logic       r_vdir_q,    w_vdir_d;
    logic [3:0] r_snd_cnt_q, w_snd_cnt_d;
    logic       w_top_evt;

    logic w_hcon_l, w_hcon_r, w_vcon_t, w_vcon_b;

    assign w_hcon_l = PIX_CE & BALL & LH_SIDE;
    assign w_hcon_r = PIX_CE & BALL & RH_SIDE;
    assign w_vcon_t = PIX_CE & BALL & TOP_BOUND;
    assign w_vcon_b = PIX_CE & BALL & BRICK_HIT;

    // Frame processing runs first so a contact in the same cycle counts
    // toward the new frame.
    always_comb begin
        w_h_state_d = r_h_state_q;
        w_v_state_d = r_v_state_q;
        w_h_seen_d  = r_h_seen_q;
        w_v_seen_d  = r_v_seen_q;
        w_hdir_d    = r_hdir_q;
        w_vdir_d    = r_vdir_q;
        w_snd_cnt_d = r_snd_cnt_q;
        w_top_evt   = 1'b0;

        if (r_frame_q) begin
            if (r_h_state_q == c_LOCKED && !r_h_seen_q) w_h_state_d = c_ARMED;
            if (r_v_state_q == c_LOCKED && !r_v_seen_q) w_v_state_d = c_ARMED;
            w_h_seen_d = 1'b0;
            w_v_seen_d = 1'b0;
            if (r_snd_cnt_q != 4'd0) w_snd_cnt_d = r_snd_cnt_q - 4'd1;
        end

        if (SERVE) begin
            w_hdir_d    = SERVE_HDIR;
            w_vdir_d    = 1'b0;
            w_h_state_d = c_ARMED;
            w_v_state_d = c_ARMED;
            w_h_seen_d  = 1'b0;
            w_v_seen_d  = 1'b0;
        end else begin
            if (w_hcon_l || w_hcon_r) begin
                w_h_seen_d = 1'b1;
                if (w_h_state_d == c_ARMED) begin
                    w_h_state_d = c_LOCKED;
                    w_hdir_d    = ~w_hcon_l;
                    w_snd_cnt_d = c_SND_LOAD;
                end
            end
            if (w_vcon_t || w_vcon_b) begin
                w_v_seen_d = 1'b1;
                if (w_v_state_d == c_ARMED) begin
                    w_v_state_d = c_LOCKED;
                    if (w_vcon_t) begin
                        w_vdir_d    = 1'b0;
                        w_top_evt   = 1'b1;
                        w_snd_cnt_d = c_SND_LOAD;
                    end else begin
                        w_vdir_d = ~r_vdir_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_vs_q      <= 1'b1;
            r_frame_q   <= 1'b0;
            r_h_state_q <= c_ARMED;
            r_v_state_q <= c_ARMED;
            r_h_seen_q  <= 1'b0;
            r_v_seen_q  <= 1'b0;
            r_hdir_q    <= 1'b0;
            r_vdir_q    <= 1'b0;
            r_snd_cnt_q <= 4'd0;
        end else begin
            r_vs_q      <= VSYNC_N;
            r_frame_q   <= r_vs_q & ~VSYNC_N;
            r_h_state_q <= w_h_state_d;
            r_v_state_q <= w_v_state_d;
            r_h_seen_q  <= w_h_seen_d;
            r_v_seen_q  <= w_v_seen_d;
            r_hdir_q    <= w_hdir_d;
            r_vdir_q    <= w_vdir_d;
            r_snd_cnt_q <= w_snd_cnt_d;
        end
    end

    assign HDIR     = r_hdir_q;
    assign VDIR     = r_vdir_q;
    assign WALL_SND = (r_snd_cnt_q != 4'd0);

`ifdef TOP_HIT_FLAG_EN
    logic r_top_hit_q, w_top_hit_d;

    always_comb begin
        w_top_hit_d = r_top_hit_q;
        if (SERVE)          w_top_hit_d = 1'b0;
        else if (w_top_evt) w_top_hit_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) r_top_hit_q <= 1'b0;
        else          r_top_hit_q <= w_top_hit_d;
    end

    assign TOP_HIT = r_top_hit_q;
`else
    assign TOP_HIT = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_boundary_collision.sv
`default_nettype none
// ============================================================================
// Module   : tb_boundary_collision
// Brief    : Directed scoreboard bench for boundary_collision.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boundary_collision;

`ifdef TOP_HIT_FLAG_EN
    localparam logic c_T = 1'b1;
`else
    localparam logic c_T = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic PIX_CE = 1'b0, VSYNC_N = 1'b1, BALL = 1'b0;
    logic TOP_BOUND = 1'b0, LH_SIDE = 1'b0, RH_SIDE = 1'b0, BRICK_HIT = 1'b0;
    logic SERVE = 1'b0, SERVE_HDIR = 1'b0;
    logic HDIR, VDIR, WALL_SND, TOP_HIT;

    boundary_collision #(.SND_FRAMES(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .PIX_CE(PIX_CE), .VSYNC_N(VSYNC_N),
        .BALL(BALL), .TOP_BOUND(TOP_BOUND), .LH_SIDE(LH_SIDE), .RH_SIDE(RH_SIDE),
        .BRICK_HIT(BRICK_HIT), .SERVE(SERVE), .SERVE_HDIR(SERVE_HDIR),
        .HDIR(HDIR), .VDIR(VDIR), .WALL_SND(WALL_SND), .TOP_HIT(TOP_HIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int   id;
        logic h, v, s, t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   id_n   = 0;

    // Monitor: compares on the falling edge after each expectation is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (HDIR !== e.h || VDIR !== e.v || WALL_SND !== e.s || TOP_HIT !== e.t) begin
                    errors++;
                    $display("FAIL chk%0d got hdir=%b vdir=%b snd=%b top=%b expected hdir=%b vdir=%b snd=%b top=%b",
                             e.id, HDIR, VDIR, WALL_SND, TOP_HIT, e.h, e.v, e.s, e.t);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_st(input logic h, input logic v, input logic s, input logic t);
        exp_t e;
        e.id = id_n; e.h = h; e.v = v; e.s = s; e.t = t;
        id_n++;
        q.push_back(e);
        tick(1);
    endtask

    task automatic pix(input logic ce, input logic lh, input logic rh,
                       input logic top, input logic brick);
        PIX_CE = ce; BALL = 1'b1; LH_SIDE = lh; RH_SIDE = rh;
        TOP_BOUND = top; BRICK_HIT = brick;
        tick(1);
        PIX_CE = 1'b0; BALL = 1'b0; LH_SIDE = 1'b0; RH_SIDE = 1'b0;
        TOP_BOUND = 1'b0; BRICK_HIT = 1'b0;
    endtask

    task automatic vsync_pulse();
        VSYNC_N = 1'b0;
        tick(1);
        VSYNC_N = 1'b1;
        tick(3);
    endtask

    task automatic serve(input logic hd);
        SERVE = 1'b1; SERVE_HDIR = hd;
        tick(1);
        SERVE = 1'b0; SERVE_HDIR = 1'b0;
    endtask

    initial begin
        // Reset then idle
        tick(2);
        RESET_N = 1'b1;
        expect_st(0, 0, 0, 0);
        tick(5);
        expect_st(0, 0, 0, 0);

        // Left wall contact held for three pixels
        serve(1);
        expect_st(1, 0, 0, 0);
        pix(1, 1, 0, 0, 0);
        expect_st(0, 0, 1, 0);
        pix(1, 1, 0, 0, 0);
        pix(1, 1, 0, 0, 0);
        expect_st(0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            vsync_pulse();
            expect_st(0, 0, (i < 4), 0);
        end

        // Lockout across frames, re-arm after an empty frame
        pix(1, 0, 1, 0, 0);
        expect_st(1, 0, 1, 0);
        pix(1, 1, 0, 0, 0);
        expect_st(1, 0, 1, 0);
        vsync_pulse();
        pix(1, 1, 0, 0, 0);
        expect_st(1, 0, 1, 0);
        vsync_pulse();
        vsync_pulse();
        pix(1, 1, 0, 0, 0);
        expect_st(0, 0, 1, 0);
        serve(0);
        expect_st(0, 0, 1, 0);
        pix(1, 0, 1, 0, 0);
        expect_st(1, 0, 1, 0);
        repeat (4) vsync_pulse();
        expect_st(1, 0, 0, 0);

        // Corner with top priority over brick
        serve(0);
        expect_st(0, 0, 0, 0);
        pix(1, 0, 0, 0, 1);
        expect_st(0, 1, 0, 0);
        vsync_pulse();
        vsync_pulse();
        pix(1, 0, 1, 1, 1);
        expect_st(1, 0, 1, c_T);

        // Brick toggles without sound; no re-toggle without a gap frame
        vsync_pulse();
        vsync_pulse();
        expect_st(1, 0, 1, c_T);
        pix(1, 0, 0, 0, 1);
        expect_st(1, 1, 1, c_T);
        vsync_pulse();
        vsync_pulse();
        expect_st(1, 1, 0, c_T);
        pix(1, 0, 0, 0, 1);
        expect_st(1, 0, 0, c_T);
        vsync_pulse();
        pix(1, 0, 0, 0, 1);
        expect_st(1, 0, 0, c_T);

        // Serve while both axes are locked
        pix(1, 1, 0, 0, 0);
        expect_st(0, 0, 1, c_T);
        serve(1);
        expect_st(1, 0, 1, 0);
        vsync_pulse();
        pix(0, 1, 0, 0, 0);
        expect_st(1, 0, 1, 0);
        pix(1, 1, 0, 0, 0);
        expect_st(0, 0, 1, 0);

        // Reset while locked with sound running
        RESET_N = 1'b0;
        tick(1);
        RESET_N = 1'b1;
        expect_st(0, 0, 0, 0);

        tick(3);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boundary_collision.md
# boundary_collision

Consumer of the playfield boundary decodes (TOP_BOUND, LH_SIDE, RH_SIDE) and the brick hit. It samples these against ball video once per pixel and owns the ball's horizontal and vertical direction bits. Each wall or brick contact produces exactly one rebound per axis, with lockout until the ball leaves the surface. It sits between the playfield decoder and the ball motion counters, and also drives the wall-bounce sound trigger.

## Interface
Parameters:
- SND_FRAMES, 4: frames WALL_SND stays high after a wall contact; legal range 1..15.

Ports:
- CLK  in  1  system clock; one clock, all logic on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- PIX_CE  in  1  pixel clock enable; boundary inputs are valid only when PIX_CE=1.
- VSYNC_N  in  1  vertical sync, active low; its falling edge marks the frame boundary.
- BALL  in  1  ball video, high on ball pixels.
- TOP_BOUND  in  1  top wall decode.
- LH_SIDE  in  1  left wall decode.
- RH_SIDE  in  1  right wall decode.
- BRICK_HIT  in  1  ball pixel coincides with a live brick.
- SERVE  in  1  one-cycle pulse that launches a new ball.
- SERVE_HDIR  in  1  horizontal direction loaded on SERVE.
- HDIR  out  1  0 = moving right, 1 = moving left.
- VDIR  out  1  0 = moving down, 1 = moving up.
- WALL_SND  out  1  wall-bounce sound gate.
- TOP_HIT  out  1  sticky flag: top wall reached since the last serve (drives paddle shrink).

## Operation
- Contact terms are evaluated only on cycles with PIX_CE=1:
  - hcon_l = BALL & LH_SIDE
  - hcon_r = BALL & RH_SIDE
  - vcon_t = BALL & TOP_BOUND
  - vcon_b = BALL & BRICK_HIT
- Each axis (H, V) has its own two-state FSM, ARMED and LOCKED, plus a seen bit.
- In ARMED, any contact on that axis:
  - updates the direction register,
  - moves the FSM to LOCKED,
  - sets seen=1.
- In LOCKED, contact only sets seen=1. Direction is never changed while LOCKED.
- At a VSYNC_N falling edge (registered edge detect, acted on the cycle after the edge is detected):
  - a LOCKED axis with seen=0 returns to ARMED,
  - seen is cleared on both axes.
- Direction updates use forced values, not toggles:
  - hcon_l sets HDIR=0.
  - hcon_r sets HDIR=1.
  - vcon_t sets VDIR=0.
  - vcon_b alone toggles VDIR.
- Simultaneous terms within one axis:
  - hcon_l and hcon_r together: hcon_l wins, HDIR=0.
  - vcon_t and vcon_b together: vcon_t wins, VDIR=0.
- H and V events in the same cycle (corner hit) update both axes independently.
- WALL_SND:
  - a 4-bit frame counter is loaded with SND_FRAMES on any ARMED→LOCKED transition caused by hcon_l, hcon_r or vcon_t. Brick hits do not load it.
  - the counter decrements at each VSYNC_N falling edge while nonzero.
  - WALL_SND = (counter != 0).
  - a new wall contact while the counter is nonzero reloads it.
- SERVE:
  - HDIR ← SERVE_HDIR, VDIR ← 0.
  - both axes go to ARMED and seen is cleared.
  - TOP_HIT is cleared.
  - the WALL_SND counter is left untouched.
- Priority: RESET_N over SERVE over contact. Contact present in the SERVE cycle is ignored.

## Timing
- Reset values: HDIR=0, VDIR=0, WALL_SND=0, TOP_HIT=0; both FSMs ARMED, seen=0, counter=0.
- Latency:
  - HDIR/VDIR change on the first CLK edge after the contacting PIX_CE cycle, i.e. 1 cycle.
  - WALL_SND rises on that same edge.
  - TOP_HIT (when built) also sets on that same edge.
- Update rate: at most one direction change per axis until a complete frame without contact on that axis has elapsed.
- Contact spanning a frame boundary stays LOCKED. It releases only at the end of the first frame with no contact.
- SERVE takes effect on the next edge. RESET_N low on any edge restores reset values, including mid-frame or while LOCKED.
- PIX_CE=0 cycles hold all state except VSYNC_N edge processing, which runs on every CLK.

## Configuration
- TOP_HIT_FLAG_EN defined:
  - TOP_HIT is set on the ARMED→LOCKED transition caused by vcon_t.
  - it is held until SERVE or reset.
- TOP_HIT_FLAG_EN undefined:
  - TOP_HIT is tied to 0 and no flop is built.
  - all other behaviour is identical.

## Test plan
- Reset then idle: RESET_N low for 2 cycles, then no BALL → HDIR=0, VDIR=0, WALL_SND=0, TOP_HIT=0 indefinitely.
- Left wall contact: with HDIR=1, hold BALL=LH_SIDE=1 for 3 PIX_CE pixels → HDIR=0 one cycle after the first pixel; no further changes; WALL_SND high for exactly 4 VSYNC_N falling edges.
- Lockout across frames: keep RH contact through frames 1 and 2, none in frame 3, contact again in frame 4 with HDIR forced to 0 via SERVE_HDIR=0 serve → HDIR=1 once in frame 1; HDIR=1 again in frame 4 only after re-arm.
- Corner and top priority: same pixel BALL=TOP_BOUND=BRICK_HIT=RH_SIDE=1 with VDIR=1, HDIR=0 → VDIR=0, HDIR=1 on the same edge; TOP_HIT=1 if TOP_HIT_FLAG_EN, else 0.
- Brick toggle without sound: BRICK_HIT contact with VDIR=1 → VDIR=0; WALL_SND stays 0. Second brick contact in the next frame with no gap frame → no change.
- SERVE mid-lock: axes LOCKED, TOP_HIT=1, then SERVE with SERVE_HDIR=1 → HDIR=1, VDIR=0, TOP_HIT=0. A new LH contact in the next frame → HDIR=0.
